// File: rtl/sd_rx_lock_ctrl.sv
// Lane deserializer lock controller: acquires comma cadence, declares lock/loss-of-lock, relocks and gives up.
// Optional feature: define SD_LOCK_STATS_EN to build the lock_loss_cnt statistics counter (tied to zero otherwise).
module sd_rx_lock_ctrl #(
  parameter int COMMA_PERIOD = 8,
  parameter int LOCK_CNT     = 4,
  parameter int UNLOCK_ERR   = 3,
  parameter int ACQ_TIMEOUT  = 1024,
  parameter int QUIET_CYC    = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  gen_mode,
  input  logic [15:0] word,
  input  logic        word_vld,
  output logic        des_enable,
  output logic [2:0]  gen_mode_out,
  output logic        lock,
  output logic        fail,
  output logic [7:0]  err_cnt,
  output logic [15:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACQUIRE = 3'd1,
    VERIFY  = 3'd2,
    LOCKED  = 3'd3,
    RELOCK  = 3'd4,
    FAIL    = 3'd5
  } state_t;

  localparam int TMAX = (ACQ_TIMEOUT > QUIET_CYC) ? ACQ_TIMEOUT : QUIET_CYC;
  localparam int PW   = (COMMA_PERIOD > 2) ? $clog2(COMMA_PERIOD) : 1;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam int GW   = $clog2(LOCK_CNT + 1);
  localparam int BW   = $clog2(UNLOCK_ERR + 1);
  localparam int RW   = $clog2(MAX_RETRY + 1);

  localparam logic [2:0]  GEN_RESET  = 3'b010;
  localparam logic [15:0] COMMA_32   = 16'hF7F7;
  localparam logic [9:0]  COMMA_20_P = 10'h17C;
  localparam logic [9:0]  COMMA_20_N = 10'h283;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] pos;
  logic [GW-1:0] good;
  logic [BW-1:0] bad;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;
  logic          free_relock;

  logic mode_32;
  logic is_comma;
  logic at_zero;
  logic comma_ok;
  logic cad_err;
  logic active;
  logic tracking;
  logic mode_chg;
  logic run;
  logic acq_hit;
  logic acq_expired;
  logic quiet_done;
  logic retry_last;
  logic lock_evt;
  logic unlock_evt;

  // ---------------------------------------------------------------------------
  // Comma detection and cadence classification of the current word
  // ---------------------------------------------------------------------------
  assign mode_32  = (gen_mode_out <= 3'b010);
  assign is_comma = mode_32 ? (word == COMMA_32)
                            : ((word[9:0] == COMMA_20_P) || (word[9:0] == COMMA_20_N));
  assign at_zero  = (pos == '0);
  assign comma_ok = word_vld && at_zero && is_comma;
  // A comma off the expected slot and a missing comma on it are both errors.
  assign cad_err  = word_vld && (at_zero != is_comma);

  assign active   = (state == ACQUIRE) || (state == VERIFY) || (state == LOCKED);
  assign tracking = (state == VERIFY) || (state == LOCKED);
  assign mode_chg = active && (gen_mode != gen_mode_out);
  assign run      = start && !mode_chg;

  assign acq_hit     = (state == ACQUIRE) && word_vld && is_comma;
  assign acq_expired = (timer == TW'(ACQ_TIMEOUT - 1));
  assign quiet_done  = (timer == TW'(QUIET_CYC - 1));
  assign retry_last  = !free_relock && (retry == RW'(MAX_RETRY - 1));
  assign lock_evt    = (state == VERIFY) && comma_ok && (good == GW'(LOCK_CNT - 1));
  assign unlock_evt  = (state == LOCKED) && cad_err && (bad == BW'(UNLOCK_ERR - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic (start=0 beats a gen_mode change beats normal flow)
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    state_nxt = state;
    if (!start) begin
      state_nxt = IDLE;
    end else if (mode_chg) begin
      state_nxt = RELOCK;
    end else begin
      case (state)
        IDLE:    state_nxt = ACQUIRE;
        ACQUIRE: begin
          if (acq_hit) begin
            state_nxt = VERIFY;
          end else if (acq_expired) begin
            state_nxt = RELOCK;
          end
        end
        VERIFY: begin
          if (cad_err) begin
            state_nxt = ACQUIRE;
          end else if (lock_evt) begin
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          if (unlock_evt) begin
            state_nxt = RELOCK;
          end
        end
        RELOCK: begin
          if (quiet_done) begin
            state_nxt = retry_last ? FAIL : ACQUIRE;
          end
        end
        FAIL:    state_nxt = FAIL;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    des_enable = 1'b0;
    lock       = 1'b0;
    fail       = 1'b0;
    case (state)
      ACQUIRE, VERIFY: des_enable = 1'b1;
      LOCKED: begin
        des_enable = 1'b1;
        lock       = 1'b1;
      end
      FAIL:    fail = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared cycle timer: ACQUIRE timeout and RELOCK quiet period
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || (state_nxt != state)) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Cadence tracking: word position, good-comma and bad-word counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pos  <= '0;
      good <= '0;
      bad  <= '0;
    end else begin
      // The acquiring comma occupies slot 0, so the next valid word is slot 1.
      if (acq_hit) begin
        pos <= PW'(1);
      end else if (tracking && word_vld) begin
        pos <= (pos == PW'(COMMA_PERIOD - 1)) ? '0 : pos + PW'(1);
      end

      if (acq_hit) begin
        good <= GW'(1);
      end else if ((state == VERIFY) && comma_ok) begin
        good <= good + GW'(1);
      end

      if (state != LOCKED || comma_ok) begin
        bad <= '0;
      end else if (cad_err) begin
        bad <= bad + BW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Relock bookkeeping and rate latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      retry        <= '0;
      free_relock  <= 1'b0;
      gen_mode_out <= GEN_RESET;
    end else begin
      if ((state_nxt == IDLE) || (state == VERIFY && state_nxt == LOCKED)) begin
        retry <= '0;
      end else if (state == RELOCK && state_nxt != RELOCK && !free_relock) begin
        retry <= retry + RW'(1);
      end

      // A rate-change relock is not charged against the retry budget.
      if (state != RELOCK && state_nxt == RELOCK) begin
        free_relock <= mode_chg;
      end

      if (state_nxt == IDLE) begin
        gen_mode_out <= GEN_RESET;
      end else if ((state == IDLE || state == RELOCK) && state_nxt != state) begin
        gen_mode_out <= gen_mode;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (state == IDLE && state_nxt == ACQUIRE) begin
      err_cnt <= '0;
    end else if (run && tracking && cad_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

`ifdef SD_LOCK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_loss_cnt <= '0;
    end else if (run && unlock_evt && (lock_loss_cnt != 16'hFFFF)) begin
      lock_loss_cnt <= lock_loss_cnt + 16'd1;
    end
  end
`else
  assign lock_loss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sd_rx_lock_ctrl.sv
// Self-checking bench for sd_rx_lock_ctrl: table-driven lock acquisition plus hand-written corner sequences.
module tb_sd_rx_lock_ctrl;

  typedef struct packed {
    logic        des_enable;
    logic [2:0]  gen_mode_out;
    logic        lock;
    logic        fail;
    logic [7:0]  err_cnt;
    logic [15:0] lock_loss_cnt;
  } out_t;

  typedef struct {
    logic        start;
    logic [2:0]  gen_mode;
    logic [15:0] word;
    logic        word_vld;
    logic        chk;
    out_t        exp;
  } vec_t;

`ifdef SD_LOCK_STATS_EN
  localparam logic [15:0] LLC1 = 16'd1;
`else
  localparam logic [15:0] LLC1 = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  gen_mode;
  logic [15:0] word;
  logic        word_vld;
  logic        des_enable;
  logic [2:0]  gen_mode_out;
  logic        lock;
  logic        fail;
  logic [7:0]  err_cnt;
  logic [15:0] lock_loss_cnt;

  int   n_tests = 0;
  int   n_fail  = 0;
  out_t exp_q[$];
  vec_t tbl[$];

  sd_rx_lock_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .gen_mode     (gen_mode),
    .word         (word),
    .word_vld     (word_vld),
    .des_enable   (des_enable),
    .gen_mode_out (gen_mode_out),
    .lock         (lock),
    .fail         (fail),
    .err_cnt      (err_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic out_t mk(input logic de, input logic [2:0] gmo, input logic lk,
                              input logic fl, input logic [7:0] ec, input logic [15:0] llc);
    out_t o;
    o = {de, gmo, lk, fl, ec, llc};
    return o;
  endfunction

  // Non-comma filler words for 32-bit mode (several are 20-bit commas or near-misses).
  function automatic logic [15:0] data32(input int i);
    case (i)
      0:       return 16'h017C;
      1:       return 16'h0283;
      2:       return 16'hF7F6;
      3:       return 16'h7FF7;
      4:       return 16'hE7F7;
      5:       return 16'h0000;
      default: return 16'hFFFF;
    endcase
  endfunction

  // Non-comma filler words for 20-bit mode (F7F7 must not count as a comma here).
  function automatic logic [15:0] data20(input int i);
    case (i)
      0:       return 16'hF7F7;
      1:       return 16'h017D;
      2:       return 16'h0282;
      3:       return 16'h037C;
      4:       return 16'h0000;
      5:       return 16'h0155;
      default: return 16'hF7F7;
    endcase
  endfunction

  function automatic void add(input logic s, input logic [2:0] g, input logic [15:0] w,
                              input logic v, input logic c, input out_t e);
    vec_t r;
    r.start = s; r.gen_mode = g; r.word = w; r.word_vld = v; r.chk = c; r.exp = e;
    tbl.push_back(r);
  endfunction

  task automatic check(input string name);
    out_t act;
    out_t exp;
    act = {des_enable, gen_mode_out, lock, fail, err_cnt, lock_loss_cnt};
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected entry queued", name);
      return;
    end
    exp = exp_q.pop_front();
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got de=%b gmo=%b lock=%b fail=%b err=%h llc=%h, want de=%b gmo=%b lock=%b fail=%b err=%h llc=%h",
               name, act.des_enable, act.gen_mode_out, act.lock, act.fail, act.err_cnt, act.lock_loss_cnt,
               exp.des_enable, exp.gen_mode_out, exp.lock, exp.fail, exp.err_cnt, exp.lock_loss_cnt);
    end
  endtask

  // Drive at the falling edge, let one rising edge sample, return at the next falling edge.
  task automatic drive(input logic s, input logic [2:0] g, input logic [15:0] w, input logic v);
    start = s; gen_mode = g; word = w; word_vld = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_chk(input logic s, input logic [2:0] g, input logic [15:0] w, input logic v,
                          input out_t e, input string name);
    exp_q.push_back(e);
    drive(s, g, w, v);
    check(name);
  endtask

  // One full ACQUIRE timeout followed by a RELOCK quiet period, with no valid words at all.
  task automatic timeout_relock(input logic last, input string tag);
    for (int k = 0; k < 1022; k++) drive(1'b1, 3'b011, 16'h0000, 1'b0);
    step_chk(1'b1, 3'b011, 16'h0000, 1'b0, mk(1, 3'b011, 0, 0, 8'd3, LLC1), {tag, "_acq_hold"});
    step_chk(1'b1, 3'b011, 16'h0000, 1'b0, mk(0, 3'b011, 0, 0, 8'd3, LLC1), {tag, "_acq_timeout"});
    for (int k = 0; k < 14; k++) drive(1'b1, 3'b011, 16'h0000, 1'b0);
    step_chk(1'b1, 3'b011, 16'h0000, 1'b0, mk(0, 3'b011, 0, 0, 8'd3, LLC1), {tag, "_quiet_hold"});
    if (last)
      step_chk(1'b1, 3'b011, 16'h0000, 1'b0, mk(0, 3'b011, 0, 1, 8'd3, LLC1), {tag, "_to_fail"});
    else
      step_chk(1'b1, 3'b011, 16'h0000, 1'b0, mk(1, 3'b011, 0, 0, 8'd3, LLC1), {tag, "_reacquire"});
  endtask

  initial begin
    // 32-bit lock acquisition table: start, then 4 commas spaced 8 valid words apart.
    add(1'b1, 3'b010, 16'h0000, 1'b0, 1'b1, mk(1, 3'b010, 0, 0, 8'd0, 16'd0));
    for (int c = 0; c < 4; c++) begin
      add(1'b1, 3'b010, 16'hF7F7, 1'b1, 1'b1, mk(1, 3'b010, (c == 3), 0, 8'd0, 16'd0));
      if (c < 3)
        for (int j = 0; j < 7; j++)
          add(1'b1, 3'b010, data32(j), 1'b1, 1'b1, mk(1, 3'b010, 0, 0, 8'd0, 16'd0));
    end

    rst = 1'b1; start = 1'b1; gen_mode = 3'b010; word = '0; word_vld = 1'b0;
    @(negedge clk);
    step_chk(1'b1, 3'b010, 16'h0000, 1'b0, mk(0, 3'b010, 0, 0, 8'd0, 16'd0), "reset");
    rst = 1'b0;

    foreach (tbl[i]) begin
      if (tbl[i].chk) exp_q.push_back(tbl[i].exp);
      drive(tbl[i].start, tbl[i].gen_mode, tbl[i].word, tbl[i].word_vld);
      if (tbl[i].chk) check($sformatf("lock32_vec%0d", i));
    end

    // Locked: one more well-placed comma, then 3 misplaced commas drop lock.
    for (int j = 0; j < 7; j++) drive(1'b1, 3'b010, data32(j), 1'b1);
    step_chk(1'b1, 3'b010, 16'hF7F7, 1'b1, mk(1, 3'b010, 1, 0, 8'd0, 16'd0), "locked_comma");
    step_chk(1'b1, 3'b010, 16'hF7F7, 1'b1, mk(1, 3'b010, 1, 0, 8'd1, 16'd0), "misplaced_1");
    step_chk(1'b1, 3'b010, 16'hF7F7, 1'b1, mk(1, 3'b010, 1, 0, 8'd2, 16'd0), "misplaced_2");
    step_chk(1'b1, 3'b010, 16'hF7F7, 1'b1, mk(0, 3'b010, 0, 0, 8'd3, LLC1), "unlock_3rd");
    for (int k = 0; k < 14; k++) drive(1'b1, 3'b010, 16'h0000, 1'b0);
    step_chk(1'b1, 3'b010, 16'h0000, 1'b0, mk(0, 3'b010, 0, 0, 8'd3, LLC1), "quiet_16th");
    step_chk(1'b1, 3'b010, 16'h0000, 1'b0, mk(1, 3'b010, 0, 0, 8'd3, LLC1), "relock_exit");

    // word_vld toggling at 50%; invalid slots carry comma values that must be ignored.
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 3'b010, 16'hF7F7, 1'b0);
      step_chk(1'b1, 3'b010, 16'hF7F7, 1'b1, mk(1, 3'b010, (c == 3), 0, 8'd3, LLC1),
               $sformatf("vld50_comma%0d", c));
      if (c < 3)
        for (int j = 0; j < 7; j++) begin
          drive(1'b1, 3'b010, 16'hF7F7, 1'b0);
          drive(1'b1, 3'b010, data32(j), 1'b1);
        end
    end

    // Rate change while locked: free relock, new rate latched after the quiet period.
    step_chk(1'b1, 3'b011, 16'h0000, 1'b0, mk(0, 3'b010, 0, 0, 8'd3, LLC1), "gm_change");
    for (int k = 0; k < 14; k++) drive(1'b1, 3'b011, 16'h0000, 1'b0);
    step_chk(1'b1, 3'b011, 16'h0000, 1'b0, mk(0, 3'b010, 0, 0, 8'd3, LLC1), "gm_quiet");
    step_chk(1'b1, 3'b011, 16'h0000, 1'b0, mk(1, 3'b011, 0, 0, 8'd3, LLC1), "gm_relatch");

    // No commas: three timeouts exhaust the retry budget (the rate relock was free).
    timeout_relock(1'b0, "to1");
    timeout_relock(1'b0, "to2");
    timeout_relock(1'b1, "to3");
    for (int k = 0; k < 4; k++) drive(1'b1, 3'b011, 16'hF7F7, 1'b1);
    step_chk(1'b1, 3'b011, 16'h0000, 1'b0, mk(0, 3'b011, 0, 1, 8'd3, LLC1), "fail_sticky");
    step_chk(1'b0, 3'b011, 16'h0000, 1'b0, mk(0, 3'b010, 0, 0, 8'd3, LLC1), "idle_after_fail");

    // 20-bit mode: F7F7 is plain data, a missing slot-0 comma restarts acquisition.
    step_chk(1'b1, 3'b100, 16'h0000, 1'b0, mk(1, 3'b100, 0, 0, 8'd0, LLC1), "start_20b");
    step_chk(1'b1, 3'b100, 16'hF7F7, 1'b1, mk(1, 3'b100, 0, 0, 8'd0, LLC1), "f7f7_in_acq");
    step_chk(1'b1, 3'b100, 16'h017C, 1'b1, mk(1, 3'b100, 0, 0, 8'd0, LLC1), "acq_17c");
    for (int j = 0; j < 7; j++) drive(1'b1, 3'b100, data20(j), 1'b1);
    step_chk(1'b1, 3'b100, 16'hF7F7, 1'b1, mk(1, 3'b100, 0, 0, 8'd1, LLC1), "no_comma_pos0");
    for (int c = 0; c < 4; c++) begin
      step_chk(1'b1, 3'b100, (c % 2 == 0) ? 16'h017C : 16'hAE83, 1'b1,
               mk(1, 3'b100, (c == 3), 0, 8'd1, LLC1), $sformatf("lock20_comma%0d", c));
      if (c < 3)
        for (int j = 0; j < 7; j++) drive(1'b1, 3'b100, data20(j), 1'b1);
    end

    // Reset while locked.
    rst = 1'b1;
    step_chk(1'b1, 3'b100, 16'h017C, 1'b1, mk(0, 3'b010, 0, 0, 8'd0, 16'd0), "rst_locked");
    rst = 1'b0;

    // Back-to-back commas: each pair is an acquisition plus a misplaced comma, driving err_cnt to saturation.
    step_chk(1'b1, 3'b010, 16'h0000, 1'b0, mk(1, 3'b010, 0, 0, 8'd0, 16'd0), "sat_start");
    for (int k = 0; k < 507; k++) drive(1'b1, 3'b010, 16'hF7F7, 1'b1);
    step_chk(1'b1, 3'b010, 16'hF7F7, 1'b1, mk(1, 3'b010, 0, 0, 8'hFE, 16'd0), "err_fe");
    drive(1'b1, 3'b010, 16'hF7F7, 1'b1);
    step_chk(1'b1, 3'b010, 16'hF7F7, 1'b1, mk(1, 3'b010, 0, 0, 8'hFF, 16'd0), "err_ff");
    for (int k = 0; k < 19; k++) drive(1'b1, 3'b010, 16'hF7F7, 1'b1);
    step_chk(1'b1, 3'b010, 16'hF7F7, 1'b1, mk(1, 3'b010, 0, 0, 8'hFF, 16'd0), "err_saturated");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
